dma_uart_responder: RTL and testbench

- Host-side memory responder for the DMA UART link. It answers the byte protocol issued by the core's low-performance DMA engine.
- Owns a 128 x 16-bit fp16 word store.
- Decodes command bytes, then either absorbs two data bytes or returns two data bytes.
- Used as the host-memory model in board bring-up and simulation, and as the host end on a companion FPGA.

---
 rtl/dma_uart_responder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dma_uart_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_uart_responder.sv
// Host-side responder for the DMA UART link: 128 x 16-bit store with preload port.
// Optional DMA_UART_RESPONDER_STATS_EN adds saturating read/write/timeout counters.

module uart_rx #(
  parameter int CPB = 2604
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_en,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'((CPB / 2 > 0) ? CPB / 2 - 1 : 0);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;

  rx_st_t          st;
  logic [1:0]      sync;
  logic [CW-1:0]   cnt;
  logic [2:0]      nbit;
  logic [7:0]      sh;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st       <= R_IDLE;
      sync     <= 2'b11;
      cnt      <= '0;
      nbit     <= '0;
      sh       <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      sync     <= {sync[0], rxd};
      rx_valid <= 1'b0;
      unique case (st)
        R_IDLE: begin
          cnt  <= '0;
          nbit <= '0;
          if (rx_en && !sync[1]) st <= R_START;
        end
        R_START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            st  <= sync[1] ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        end
        R_DATA: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sh   <= {sync[1], sh[7:1]};
            nbit <= nbit + 1'b1;
            if (nbit == 3'd7) st <= R_STOP;
          end else cnt <= cnt + 1'b1;
        end
        R_STOP: begin
          if (cnt == LAST) begin
            st       <= R_IDLE;
            rx_valid <= sync[1];
            rx_data  <= sh;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= R_IDLE;
      endcase
    end
  end
endmodule

module uart_tx #(
  parameter int CPB = 2604
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd
);
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  logic [CW-1:0] cnt;
  logic [3:0]    nbit;
  logic [8:0]    sh;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_busy <= 1'b0;
      txd     <= 1'b1;
      cnt     <= '0;
      nbit    <= '0;
      sh      <= '1;
    end else if (!tx_busy) begin
      if (tx_en) begin
        tx_busy <= 1'b1;
        txd     <= 1'b0;
        sh      <= {1'b1, tx_data};
        cnt     <= '0;
        nbit    <= '0;
      end
    end else if (cnt == LAST) begin
      cnt <= '0;
      if (nbit == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        txd  <= sh[0];
        sh   <= {1'b1, sh[8:1]};
        nbit <= nbit + 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module dma_uart_responder #(
  parameter int CLK_HZ         = 50000000,
  parameter int BIT_RATE       = 19200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        busy,
  output logic        mem_wr_strobe,
  output logic [6:0]  mem_wr_addr,
  output logic [15:0] mem_wr_data,
  output logic        err_timeout,
  input  logic        pre_we,
  input  logic [6:0]  pre_addr,
  input  logic [15:0] pre_wdata,
  output logic [15:0] pre_rdata
`ifdef DMA_UART_RESPONDER_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_timeouts
`endif
);
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WR_MSB, WR_LSB, WR_COMMIT, RD_FETCH,
    RD_MSB_0, RD_MSB_1, RD_MSB_2,
    RD_LSB_0, RD_LSB_1, RD_LSB_2
  } state_t;

  state_t        state, nxt;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_en, tx_busy, timeout;
  logic [7:0]    tx_data;
  logic [6:0]    addr_q;
  logic [7:0]    msb_q;
  logic [15:0]   wdata_q, word_q;
  logic [TW-1:0] to_cnt;
  logic [15:0]   mem [128];
  logic          commit, pre_hit, rd_done;

  uart_rx #(.CPB(CPB)) u_rx (
    .clk(clk), .resetn(resetn), .rx_en(1'b1), .rxd(uart_rxd),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  uart_tx #(.CPB(CPB)) u_tx (
    .clk(clk), .resetn(resetn), .tx_en(tx_en), .tx_data(tx_data),
    .tx_busy(tx_busy), .txd(uart_txd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt     = state;
    tx_en   = 1'b0;
    tx_data = 8'h00;
    timeout = 1'b0;
    unique case (state)
      IDLE:      if (rx_valid) nxt = rx_data[7] ? WR_MSB : RD_FETCH;
      WR_MSB, WR_LSB: begin
        if (rx_valid) begin
          nxt = (state == WR_MSB) ? WR_LSB : WR_COMMIT;
        end else if (to_cnt == TO_LAST) begin
          timeout = 1'b1;
          nxt     = IDLE;
        end
      end
      WR_COMMIT: nxt = IDLE;
      RD_FETCH:  nxt = RD_MSB_0;
      RD_MSB_0, RD_LSB_0: begin
        tx_en   = 1'b1;
        tx_data = word_q[15:8];
        nxt     = (state == RD_MSB_0) ? RD_MSB_1 : RD_LSB_1;
      end
      RD_MSB_1:  nxt = RD_MSB_2;
      RD_LSB_1:  nxt = RD_LSB_2;
      RD_MSB_2:  if (!tx_busy) nxt = RD_LSB_0;
      RD_LSB_2:  if (!tx_busy) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // word_q shifts left after the MSB so both bytes leave from [15:8]
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      msb_q   <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == IDLE && rx_valid) begin
        addr_q <= rx_data[6:0];
        to_cnt <= '0;
      end
      if (state == WR_MSB || state == WR_LSB) begin
        if (rx_valid) to_cnt <= '0;
        else          to_cnt <= to_cnt + 1'b1;
      end
      if (state == WR_MSB && rx_valid) msb_q <= rx_data;
      if (state == WR_LSB && rx_valid) wdata_q <= {msb_q, rx_data};
      if (state == RD_FETCH) word_q <= mem[addr_q];
      if (state == RD_MSB_2 && !tx_busy) word_q <= {word_q[7:0], 8'h00};
    end
  end

  assign commit  = (state == WR_COMMIT);
  assign pre_hit = commit && (pre_addr == addr_q);
  assign rd_done = (state == RD_LSB_2) && !tx_busy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
      pre_rdata <= '0;
    end else begin
      if (commit) mem[addr_q] <= wdata_q;
      if (pre_we && !pre_hit) mem[pre_addr] <= pre_wdata;
      if (pre_hit)     pre_rdata <= wdata_q;
      else if (pre_we) pre_rdata <= pre_wdata;
      else             pre_rdata <= mem[pre_addr];
    end
  end

  assign busy          = (state != IDLE);
  assign mem_wr_strobe = commit;
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = wdata_q;
  assign err_timeout   = timeout;

`ifdef DMA_UART_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_reads    <= '0;
      stat_writes   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (rd_done && stat_reads != 16'hFFFF)
        stat_reads <= stat_reads + 1'b1;
      if (commit && stat_writes != 16'hFFFF)
        stat_writes <= stat_writes + 1'b1;
      if (timeout && stat_timeouts != 16'hFFFF)
        stat_timeouts <= stat_timeouts + 1'b1;
    end
  end
`else
  logic unused_rd_done;
  assign unused_rd_done = rd_done;
`endif

endmodule

// File: tb/tb_dma_uart_responder.sv
// Scoreboard bench for dma_uart_responder: serial reads/writes, timeout,
// preload collision and mid-read reset; stats checked when enabled.

module tb_dma_uart_responder;
  localparam int CLK_HZ   = 1000000;
  localparam int BIT_RATE = 100000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int TO_CYC   = 1000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        uart_rxd;
  logic        uart_txd;
  logic        busy;
  logic        mem_wr_strobe;
  logic [6:0]  mem_wr_addr;
  logic [15:0] mem_wr_data;
  logic        err_timeout;
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [15:0] pre_wdata;
  logic [15:0] pre_rdata;
`ifdef DMA_UART_RESPONDER_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_timeouts;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int to_pulses = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [22:0] wr_q[$];
  logic [22:0] wexp_q[$];

  dma_uart_responder #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd),
    .busy(busy),
    .mem_wr_strobe(mem_wr_strobe),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .err_timeout(err_timeout),
    .pre_we(pre_we), .pre_addr(pre_addr),
    .pre_wdata(pre_wdata), .pre_rdata(pre_rdata)
`ifdef DMA_UART_RESPONDER_STATS_EN
    ,
    .stat_reads(stat_reads),
    .stat_writes(stat_writes),
    .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge uart_txd);
      repeat (CPB + CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        b[i] = uart_txd;
        if (i < 7) repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
      got_q.push_back(b);
    end
  end

  always @(negedge clk) begin
    if (resetn && mem_wr_strobe) wr_q.push_back({mem_wr_addr, mem_wr_data});
    if (resetn && err_timeout) to_pulses++;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic peek(input logic [6:0] a, input logic [15:0] e, input string nm);
    pre_addr = a;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (pre_rdata !== e) begin
      n_bad++;
      $display("FAIL %s: mem[%h] got %h want %h", nm, a, pre_rdata, e);
    end
  endtask

  task automatic read_cmd(input logic [6:0] a, input logic [15:0] e);
    logic [7:0] g, x;
    int n;
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    send_byte({1'b0, a});
    n = 0;
    while (got_q.size() < 2 && n < 800) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (got_q.size() < 2) begin
      n_bad++;
      $display("FAIL read_resp addr=%h: got %0d bytes want 2", a, got_q.size());
      got_q.delete();
      exp_q.delete();
    end else begin
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_in_stop addr=%h: got %b want 1", a, busy);
      end
      for (int i = 0; i < 2; i++) begin
        g = got_q.pop_front();
        x = exp_q.pop_front();
        n_cmp++;
        if (g !== x) begin
          n_bad++;
          $display("FAIL read_byte%0d addr=%h: got %h want %h", i, a, g, x);
        end
      end
      n = 0;
      while (busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_release addr=%h: got %b want 0", a, busy);
      end
    end
  endtask

  task automatic write_cmd(input logic [6:0] a, input logic [15:0] d);
    logic [22:0] g, x;
    wexp_q.push_back({a, d});
    send_byte({1'b1, a});
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL wr_strobe_count addr=%h: got %0d want 1", a, wr_q.size());
      wr_q.delete();
      wexp_q.delete();
    end else begin
      g = wr_q.pop_front();
      x = wexp_q.pop_front();
      n_cmp++;
      if (g !== x) begin
        n_bad++;
        $display("FAIL wr_strobe: got %h/%h want %h/%h",
                 g[22:16], g[15:0], x[22:16], x[15:0]);
      end
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    uart_rxd  = 1'b1;
    pre_we    = 1'b0;
    pre_addr  = 7'h05;
    pre_wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({uart_txd, busy, mem_wr_strobe, err_timeout} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_outs: txd/busy/strb/err got %b want 1000",
               {uart_txd, busy, mem_wr_strobe, err_timeout});
    end
    n_cmp++;
    if (pre_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_pre_rdata: got %h want 0000", pre_rdata);
    end
    resetn = 1'b1;
    peek(7'h05, 16'h0000, "post_reset_mem");
  endtask

  task automatic test_preload_read();
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 7'h05; pre_wdata = 16'h5248;
    @(negedge clk);
    pre_we = 1'b0;
    read_cmd(7'h05, 16'h5248);
  endtask

  task automatic test_write();
    write_cmd(7'h03, 16'hD248);
    read_cmd(7'h03, 16'hD248);
    peek(7'h03, 16'hD248, "write_pre_rdata");
  endtask

  task automatic test_timeout();
    int t0;
    t0 = to_pulses;
    send_byte(8'h81);
    send_byte(8'hAA);
    repeat (TO_CYC + 200) @(negedge clk);
    n_cmp++;
    if (to_pulses - t0 != 1) begin
      n_bad++;
      $display("FAIL timeout_pulses: got %0d want 1", to_pulses - t0);
    end
    n_cmp++;
    if (wr_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_abort: strobes %0d busy %b want 0 0", wr_q.size(), busy);
      wr_q.delete();
    end
    peek(7'h01, 16'h0000, "timeout_mem_kept");
    write_cmd(7'h01, 16'h1234);
    peek(7'h01, 16'h1234, "after_timeout_write");
  endtask

  task automatic collide(input logic [6:0] wa, input logic [15:0] wd,
                         input logic [6:0] pa, input logic [15:0] pd);
    logic hit;
    logic [22:0] g;
    hit = 1'b0;
    send_byte({1'b1, wa});
    send_byte(wd[15:8]);
    fork
      send_byte(wd[7:0]);
      begin
        for (int n = 0; n < 300 && !hit; n++) begin
          @(negedge clk);
          if (mem_wr_strobe) hit = 1'b1;
        end
        if (hit) begin
          pre_we = 1'b1; pre_addr = pa; pre_wdata = pd;
          @(negedge clk);
          pre_we = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!hit || wr_q.size() != 1) begin
      n_bad++;
      $display("FAIL collide_strobe: seen %b count %0d want 1 1", hit, wr_q.size());
      wr_q.delete();
    end else begin
      g = wr_q.pop_front();
      n_cmp++;
      if (g !== {wa, wd}) begin
        n_bad++;
        $display("FAIL collide_wr: got %h want %h", g, {wa, wd});
      end
    end
    peek(wa, wd, "collide_uart_word");
    if (pa != wa) peek(pa, pd, "collide_pre_word");
  endtask

  task automatic test_collision();
    collide(7'h03, 16'hBEEF, 7'h03, 16'h1111);
    collide(7'h03, 16'h0F0F, 7'h04, 16'h2222);
  endtask

  task automatic test_reset_mid_read();
    int bad;
    send_byte(8'h05);
    repeat (60) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (uart_txd !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset: txd %b busy %b want 1 0", uart_txd, busy);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      pre_addr = 7'(i);
      @(negedge clk);
      if (pre_rdata !== 16'h0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL mid_reset_clear: %0d nonzero words want 0", bad);
    end
    repeat (200) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    wr_q.delete();
    read_cmd(7'h05, 16'h0000);
  endtask

`ifdef DMA_UART_RESPONDER_STATS_EN
  task automatic test_stats();
    do_reset();
    write_cmd(7'h10, 16'hA001);
    write_cmd(7'h11, 16'hA002);
    write_cmd(7'h12, 16'hA003);
    read_cmd(7'h10, 16'hA001);
    read_cmd(7'h12, 16'hA003);
    send_byte(8'h81);
    send_byte(8'hAA);
    repeat (TO_CYC + 200) @(negedge clk);
    n_cmp++;
    if ({stat_reads, stat_writes, stat_timeouts} !== {16'd2, 16'd3, 16'd1}) begin
      n_bad++;
      $display("FAIL stats: r/w/t got %0d/%0d/%0d want 2/3/1",
               stat_reads, stat_writes, stat_timeouts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_preload_read();
    test_write();
    test_timeout();
    test_collision();
    test_reset_mid_read();
`ifdef DMA_UART_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
